// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake bundle of uart_rx_fifo: head-of-FIFO word, valid, ready and occupancy.
// The receiver drives it through the master modport and the consumer uses the slave modport.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic [DATA_W-1:0]          tx_o;
  logic                       tx_o_v;
  logic                       rdy_i;
  logic [$clog2(DEPTH+1)-1:0] level_o;

  modport master (output tx_o, output tx_o_v, output level_o, input rdy_i);
  modport slave  (input tx_o, input tx_o_v, input level_o, output rdy_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// Single-clock oversampling UART receiver feeding a first-word-fall-through FIFO.
// A tick counter paces sampling, and a valid/ready pop lets the consumer apply backpressure.
module uart_rx_fifo #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int OS       = 16,
  parameter int DATA_W   = 8,
  parameter int PARITY   = 0,
  parameter int DEPTH    = 16
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           rx_i,
  uart_rx_fifo_if.master bus,
  output logic           frame_err_o,
  output logic           par_err_o,
  output logic           ovf_o
);
  localparam int DIV = CLK_FREQ / (BAUD * OS);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW = $clog2(OS);
  localparam int BW  = $clog2(DATA_W + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam logic ODD_PAR = (PARITY == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic              r_sync1, r_sync2;
  state_t            r_state;
  logic [TW-1:0]     r_tick_cnt;
  logic [OSW-1:0]    r_os_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_flag;
  logic              r_push;
  logic [DATA_W-1:0] r_push_data;
  logic              r_frame_err;
  logic              r_par_err;
  logic              r_ovf;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;

  logic w_rx_s, w_tick, w_mid, w_bit_end, w_empty, w_full, w_pop, w_wr;

  assign w_rx_s    = r_sync2;
  assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == TW'(DIV - 1));
  assign w_mid     = w_tick && (r_os_cnt == OSW'(OS / 2 - 1));
  assign w_bit_end = w_tick && (r_os_cnt == OSW'(OS - 1));
  assign w_empty   = (r_level == {LW{1'b0}});
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = !w_empty && bus.rdy_i;
  // At full a push only lands when a pop frees the head slot in the same cycle.
  assign w_wr      = r_push && (!w_full || w_pop);

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // Oversampling tick divider, parked at zero while the receiver is idle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || r_state == S_IDLE) begin
      r_tick_cnt <= {TW{1'b0}};
    end else if (r_tick_cnt == TW'(DIV - 1)) begin
      r_tick_cnt <= {TW{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Frame receive state machine with registered push request and error pulses.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_os_cnt    <= {OSW{1'b0}};
      r_bit_cnt   <= {BW{1'b0}};
      r_shift     <= {DATA_W{1'b0}};
      r_par_flag  <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= {DATA_W{1'b0}};
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_os_cnt   <= {OSW{1'b0}};
          r_bit_cnt  <= {BW{1'b0}};
          r_par_flag <= 1'b0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (w_mid) begin
            r_os_cnt <= {OSW{1'b0}};
            r_state  <= w_rx_s ? S_IDLE : S_DATA;
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + OSW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_os_cnt  <= {OSW{1'b0}};
            r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
            if (r_bit_cnt == BW'(DATA_W - 1)) r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + OSW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_os_cnt   <= {OSW{1'b0}};
            r_par_flag <= w_rx_s ^ (^r_shift) ^ ODD_PAR;
            r_state    <= S_STOP;
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + OSW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_os_cnt <= {OSW{1'b0}};
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end else if (r_par_flag) begin
              r_par_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_push      <= 1'b1;
              r_push_data <= r_shift;
              r_state     <= S_IDLE;
            end
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + OSW'(1);
          end
        end
        S_BREAK: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= r_push && !w_wr;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.tx_o    = w_empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr];
  assign bus.tx_o_v  = !w_empty;
  assign bus.level_o = r_level;
  assign frame_err_o = r_frame_err;
  assign par_err_o   = r_par_err;
  assign ovf_o       = r_ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: three receivers (no/even/odd parity) on separate lines,
// expected words queued at stimulus time and popped by a negedge monitor on every handshake.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   nfe[3];
  int   npe[3];
  int   nov[3];
  int   vcnt0 = 0;
  int   first_v0 = -1;
  int   t0;
  int   base;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(4)) if0 ();
  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(4)) if1 ();
  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(4)) if2 ();

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .OS(16), .DATA_W(8), .PARITY(0), .DEPTH(4)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx0), .bus(if0),
    .frame_err_o(fe0), .par_err_o(pe0), .ovf_o(ov0));
  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .OS(16), .DATA_W(8), .PARITY(1), .DEPTH(4)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx1), .bus(if1),
    .frame_err_o(fe1), .par_err_o(pe1), .ovf_o(ov1));
  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .OS(16), .DATA_W(8), .PARITY(2), .DEPTH(4)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx2), .bus(if2),
    .frame_err_o(fe2), .par_err_o(pe2), .ovf_o(ov2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_pop(input int k, input logic [7:0] act);
    logic [7:0] e;
    bit got;
    got = 1'b0;
    e = 8'h00;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      default: got = 1'b0;
    endcase
    total++;
    if (!got) begin
      bad++;
      $display("FAIL pop%0d: got unexpected word 0x%02h, expected none", k, act);
    end else if (act !== e) begin
      bad++;
      $display("FAIL pop%0d: got 0x%02h, expected 0x%02h", k, act, e);
    end
  endtask

  // Monitor: scoreboard pops on every handshake, plus pulse and valid-cycle counters.
  always @(negedge clk) begin
    if (if0.tx_o_v === 1'b1) begin
      vcnt0++;
      if (first_v0 < 0) first_v0 = cyc;
    end
    if (if0.tx_o_v === 1'b1 && if0.rdy_i === 1'b1) chk_pop(0, if0.tx_o);
    if (if1.tx_o_v === 1'b1 && if1.rdy_i === 1'b1) chk_pop(1, if1.tx_o);
    if (if2.tx_o_v === 1'b1 && if2.rdy_i === 1'b1) chk_pop(2, if2.tx_o);
    if (fe0 === 1'b1) nfe[0]++;
    if (fe1 === 1'b1) nfe[1]++;
    if (fe2 === 1'b1) nfe[2]++;
    if (pe0 === 1'b1) npe[0]++;
    if (pe1 === 1'b1) npe[1]++;
    if (pe2 === 1'b1) npe[2]++;
    if (ov0 === 1'b1) nov[0]++;
    if (ov1 === 1'b1) nov[1]++;
    if (ov2 === 1'b1) nov[2]++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int k, input logic v);
    case (k)
      0: rx0 = v;
      1: rx1 = v;
      2: rx2 = v;
      default: rx0 = 1'b1;
    endcase
  endtask

  // One frame: start, 8 data bits LSB first, optional parity bit, stop bit (value given).
  task automatic send(input int k, input logic [7:0] d, input bit has_par, input logic pbit,
                      input logic stopb);
    set_rx(k, 1'b0);
    step(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(k, d[i]);
      step(16);
    end
    if (has_par) begin
      set_rx(k, pbit);
      step(16);
    end
    set_rx(k, stopb);
    step(16);
    set_rx(k, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      nfe[i] = 0;
      npe[i] = 0;
      nov[i] = 0;
    end
    if0.rdy_i = 1'b1;
    if1.rdy_i = 1'b1;
    if2.rdy_i = 1'b1;

    // 1: reset and basic receive with latency
    rstn = 1'b0;
    step(3);
    check("rst_valid", int'(if0.tx_o_v), 0);
    check("rst_level", int'(if0.level_o), 0);
    check("rst_data", int'(if0.tx_o), 0);
    rstn = 1'b1;
    step(5);
    vcnt0 = 0;
    first_v0 = -1;
    t0 = cyc;
    q0.push_back(8'hA5);
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    step(20);
    check("t1_latency", first_v0, t0 + 156);
    check("t1_valid_cycles", vcnt0, 1);
    check("t1_level", int'(if0.level_o), 0);

    // 2: backpressure and overflow
    if0.rdy_i = 1'b0;
    base = nov[0];
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q0.push_back(8'(i));
      send(0, 8'(i), 1'b0, 1'b0, 1'b1);
    end
    step(5);
    check("t2_level_full", int'(if0.level_o), 4);
    check("t2_ovf_pulses", nov[0] - base, 1);
    check("t2_head_held", int'(if0.tx_o), 1);
    if0.rdy_i = 1'b1;
    step(10);
    check("t2_drained_valid", int'(if0.tx_o_v), 0);
    check("t2_drained_level", int'(if0.level_o), 0);

    // 3: even and odd parity
    q1.push_back(8'h03);
    send(1, 8'h03, 1'b1, 1'b0, 1'b1);
    base = npe[1];
    send(1, 8'h03, 1'b1, 1'b1, 1'b1);
    step(20);
    check("t3_even_perr", npe[1] - base, 1);
    check("t3_even_level", int'(if1.level_o), 0);
    q2.push_back(8'h07);
    send(2, 8'h07, 1'b1, 1'b0, 1'b1);
    step(20);
    check("t3_odd_ok_perr", npe[2], 0);
    send(2, 8'h07, 1'b1, 1'b1, 1'b1);
    step(20);
    check("t3_odd_bad_perr", npe[2], 1);
    check("t3_no_frame_err", nfe[1] + nfe[2], 0);

    // 4: framing error followed by a long break
    base = nfe[0];
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    rx0 = 1'b0;
    step(50 * 16);
    rx0 = 1'b1;
    step(32);
    check("t4_frame_err", nfe[0] - base, 1);
    check("t4_no_push", int'(if0.level_o), 0);
    q0.push_back(8'h3C);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(20);
    check("t4_after_break_q", q0.size(), 0);

    // 5: start-bit glitch, then reset mid-frame
    base = nfe[0];
    rx0 = 1'b0;
    step(4);
    rx0 = 1'b1;
    step(40);
    check("t5_glitch_level", int'(if0.level_o), 0);
    check("t5_glitch_ferr", nfe[0] - base, 0);
    rx0 = 1'b0;
    step(16);
    rx0 = 1'b1;
    step(64);
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    step(100);
    check("t5_reset_level", int'(if0.level_o), 0);
    q0.push_back(8'h81);
    send(0, 8'h81, 1'b0, 1'b0, 1'b1);
    step(20);
    check("t5_after_reset_q", q0.size(), 0);

    // 6: full FIFO with a pop coinciding with the next push
    if0.rdy_i = 1'b0;
    base = nov[0];
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'h10 + 8'(i));
      send(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    end
    step(2);
    check("t6_level_full", int'(if0.level_o), 4);
    q0.push_back(8'h14);
    fork
      send(0, 8'h14, 1'b0, 1'b0, 1'b1);
      begin
        step(155);
        if0.rdy_i = 1'b1;
        step(1);
        if0.rdy_i = 1'b0;
      end
    join
    step(5);
    check("t6_level_kept", int'(if0.level_o), 4);
    check("t6_no_ovf", nov[0] - base, 0);
    check("t6_new_head", int'(if0.tx_o), 8'h11);
    if0.rdy_i = 1'b1;
    step(10);
    check("t6_drained_level", int'(if0.level_o), 0);

    check("end_q0_empty", q0.size(), 0);
    check("end_q1_empty", q1.size(), 0);
    check("end_q2_empty", q2.size(), 0);
    check("end_stray_ovf", nov[1] + nov[2], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
